// File: rtl/flash_pkg.sv
// Shared definitions for the flash responder: command opcodes, status-register
// bit positions and the controller state encoding.
package flash_pkg;

    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
    localparam logic [7:0] CMD_READ_STATUS = 8'h70;
    localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
    localparam logic [7:0] CMD_PROG        = 8'h40;
    localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
    localparam logic [7:0] CMD_ERASE       = 8'h20;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_LOCKED    = 1;

    localparam logic [7:0] SR_RESET = 8'h80;

    typedef enum logic [2:0] {
        ST_READ_ARRAY  = 3'd0,
        ST_READ_STATUS = 3'd1,
        ST_PROG_SETUP  = 3'd2,
        ST_PROG_BUSY   = 3'd3,
        ST_ERASE_SETUP = 3'd4,
        ST_ERASE_BUSY  = 3'd5
    } flash_state_e;

    function automatic logic is_busy(input flash_state_e st);
        return (st == ST_PROG_BUSY) || (st == ST_ERASE_BUSY);
    endfunction

endpackage

// File: rtl/flash_sync.sv
// Two-flop synchronizer for one asynchronous bus strobe, with a third flop
// so the synchronized rising edge comes out as a single-cycle pulse.
module flash_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain plus edge-history flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/flash_responder.sv
// Behavioural NOR-flash target: 256x8 array behind an asynchronous byte bus,
// with program, erase, status register and write protection.
module flash_responder
    import flash_pkg::*;
#(
    parameter int PROG_CYCLES  = 16,
    parameter int ERASE_CYCLES = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       NF_CE,
    input  logic       NF_OE,
    input  logic       NF_WE,
    input  logic       NF_RP,
    input  logic       NF_WP,
    input  logic       NF_BYTE,
    input  logic [7:0] NF_A,
    inout  wire  [7:0] NF_D,
    output logic       NF_STS
);

    localparam int MAX_CYCLES = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERASE_SPAN = CNT_W'(256);

    flash_state_e     state_q, state_d;
    logic [18:0]      sync1_q, sync2_q;
    logic             ce_s, rp_s, wp_s, we_rise_s, wr_s;
    logic [7:0]       a_s, d_s;
    logic [7:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_addr_q, cmd_addr_d, cmd_data_q, cmd_data_d;
    logic             ram_we_s;
    logic [7:0]       ram_wa_s, ram_wd_s, rd_addr_s;
    logic [7:0]       mem_q [256];
    logic [7:0]       ram_q;
    logic             array_sel_q;
    logic [7:0]       sr_out_q;
    logic [7:0]       rd_data_s;
    logic             unused_byte_s;

    assign unused_byte_s = NF_BYTE;

    // Bus synchronizers for CE, RP, WP, address and data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 19'd0;
            sync2_q <= 19'd0;
        end else begin
            sync1_q <= {NF_CE, NF_RP, NF_WP, NF_A, NF_D};
            sync2_q <= sync1_q;
        end
    end

    assign ce_s = sync2_q[18];
    assign rp_s = sync2_q[17];
    assign wp_s = sync2_q[16];
    assign a_s  = sync2_q[15:8];
    assign d_s  = sync2_q[7:0];

    flash_sync u_we_sync (
        .clk_i  (CLK),
        .rst_i  (RST),
        .d_i    (NF_WE),
        .rise_o (we_rise_s)
    );

    assign wr_s = we_rise_s & ~ce_s & rp_s;

    // Controller state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_READ_ARRAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; busy completion ignores writes since they are dropped while busy.
    always_comb begin
        state_d = state_q;
        if (!rp_s) begin
            state_d = ST_READ_ARRAY;
        end else begin
            case (state_q)
                ST_READ_ARRAY, ST_READ_STATUS: begin
                    if (wr_s) begin
                        case (d_s)
                            CMD_READ_ARRAY:         state_d = ST_READ_ARRAY;
                            CMD_READ_STATUS:        state_d = ST_READ_STATUS;
                            CMD_PROG, CMD_PROG_ALT: state_d = ST_PROG_SETUP;
                            CMD_ERASE:              state_d = ST_ERASE_SETUP;
                            default:                state_d = state_q;
                        endcase
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PROG_SETUP: begin
                    if (wr_s) begin
                        state_d = wp_s ? ST_PROG_BUSY : ST_READ_STATUS;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ERASE_SETUP: begin
                    if (wr_s) begin
                        state_d = ((d_s == CMD_CONFIRM) && wp_s) ? ST_ERASE_BUSY : ST_READ_STATUS;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PROG_BUSY: begin
                    if (cnt_q == PROG_LAST) begin
                        state_d = ST_READ_STATUS;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ERASE_BUSY: begin
                    if (cnt_q == ERASE_LAST) begin
                        state_d = ST_READ_STATUS;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_READ_ARRAY;
            endcase
        end
    end

    // Status, counter, command capture and array write port per state.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        ram_we_s   = 1'b0;
        ram_wa_s   = cnt_q[7:0];
        ram_wd_s   = 8'hFF;
        if (!rp_s) begin
            sr_d  = SR_RESET;
            cnt_d = CNT_ZERO;
        end else begin
            if (wr_s && !is_busy(state_q)) begin
                cmd_addr_d = a_s;
                cmd_data_d = d_s;
            end else begin
                cmd_addr_d = cmd_addr_q;
                cmd_data_d = cmd_data_q;
            end
            case (state_q)
                ST_READ_ARRAY, ST_READ_STATUS: begin
                    if (wr_s && (d_s == CMD_CLEAR_SR)) begin
                        sr_d[SR_ERASE_ERR] = 1'b0;
                        sr_d[SR_PROG_ERR]  = 1'b0;
                        sr_d[SR_LOCKED]    = 1'b0;
                    end else begin
                        sr_d = sr_q;
                    end
                end
                ST_PROG_SETUP: begin
                    cnt_d = CNT_ZERO;
                    if (wr_s && !wp_s) begin
                        sr_d[SR_LOCKED]   = 1'b1;
                        sr_d[SR_PROG_ERR] = 1'b1;
                    end else begin
                        sr_d = sr_q;
                    end
                end
                ST_ERASE_SETUP: begin
                    cnt_d = CNT_ZERO;
                    if (wr_s && (d_s != CMD_CONFIRM)) begin
                        sr_d[SR_ERASE_ERR] = 1'b1;
                        sr_d[SR_PROG_ERR]  = 1'b1;
                    end else if (wr_s && !wp_s) begin
                        sr_d[SR_LOCKED]    = 1'b1;
                        sr_d[SR_ERASE_ERR] = 1'b1;
                    end else begin
                        sr_d = sr_q;
                    end
                end
                // Cycle 0 reads the target byte, cycle 1 writes back the AND.
                ST_PROG_BUSY: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        ram_we_s = 1'b1;
                        ram_wa_s = cmd_addr_q;
                        ram_wd_s = ram_q & cmd_data_q;
                    end else begin
                        ram_we_s = 1'b0;
                    end
                end
                ST_ERASE_BUSY: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q < ERASE_SPAN) begin
                        ram_we_s = 1'b1;
                    end else begin
                        ram_we_s = 1'b0;
                    end
                end
                default: sr_d = sr_q;
            endcase
            sr_d[SR_READY] = ~is_busy(state_d);
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_q        <= SR_RESET;
            cnt_q       <= CNT_ZERO;
            cmd_addr_q  <= 8'h00;
            cmd_data_q  <= 8'h00;
            array_sel_q <= 1'b1;
            sr_out_q    <= SR_RESET;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            array_sel_q <= (state_q == ST_READ_ARRAY);
            sr_out_q    <= sr_q;
        end
    end

    assign rd_addr_s = (state_q == ST_READ_ARRAY) ? a_s : cmd_addr_q;

    // Synchronous single-port array; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            mem_q[ram_wa_s] <= ram_wd_s;
        end
        ram_q <= mem_q[rd_addr_s];
    end

    assign rd_data_s = array_sel_q ? ram_q : sr_out_q;
    assign NF_D      = (!NF_CE && !NF_OE && NF_WE && NF_RP && !RST) ? rd_data_s : 8'hzz;
    assign NF_STS    = sr_q[SR_READY];

endmodule

// File: tb/tb_flash_responder.sv
// Randomized self-checking bench for flash_responder against an array/status model.
module tb_flash_responder;

    localparam int PROG_CYCLES  = 16;
    localparam int ERASE_CYCLES = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nf_ce = 1'b1, nf_oe = 1'b1, nf_we = 1'b1, nf_rp = 1'b1, nf_wp = 1'b1, nf_byte = 1'b0;
    logic [7:0] nf_a = 8'h00;
    logic [7:0] d_drv = 8'h00;
    logic       d_oe = 1'b0;
    wire  [7:0] nf_d;
    logic       nf_sts;

    logic [7:0] model_mem [256];
    logic [7:0] model_sr = 8'h80;
    int         n_checks = 0;
    int         n_pass = 0;

    assign nf_d = d_oe ? d_drv : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (nf_d[g]);
    end

    always #5 clk = ~clk;

    flash_responder #(.PROG_CYCLES(PROG_CYCLES), .ERASE_CYCLES(ERASE_CYCLES)) dut (
        .CLK(clk), .RST(rst), .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we),
        .NF_RP(nf_rp), .NF_WP(nf_wp), .NF_BYTE(nf_byte), .NF_A(nf_a),
        .NF_D(nf_d), .NF_STS(nf_sts)
    );

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        nf_a = a; d_drv = d; d_oe = 1'b1; nf_ce = 1'b0; nf_we = 1'b0;
        repeat (3) @(negedge clk);
        nf_we = 1'b1;
        repeat (3) @(negedge clk);
        nf_ce = 1'b1; d_oe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Write cycle that also counts the cycles NF_STS is seen low afterwards.
    task automatic write_timed(input logic [7:0] a, input logic [7:0] d, input int budget, output int low);
        low = 0;
        @(negedge clk);
        nf_a = a; d_drv = d; d_oe = 1'b1; nf_ce = 1'b0; nf_we = 1'b0;
        repeat (3) @(negedge clk);
        nf_we = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 3) begin nf_ce = 1'b1; d_oe = 1'b0; end
            if (nf_sts === 1'b0) low++;
            else if (low > 0) break;
        end
        nf_ce = 1'b1; d_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        nf_a = a; nf_ce = 1'b0; nf_oe = 1'b0;
        repeat (4) @(negedge clk);
        d = nf_d;
        nf_oe = 1'b1; nf_ce = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (nf_sts !== 1'b1) $display("FAIL reset_sts: got %b expected 1", nf_sts); else n_pass++;
        nf_ce = 1'b0; nf_oe = 1'b0; #1;
        n_checks++;
        if (nf_d !== 8'hFF) $display("FAIL reset_bus_released: got %h expected FF (pulled up)", nf_d); else n_pass++;
        nf_ce = 1'b1; nf_oe = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(8'h00, 8'h70);
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL reset_sr: got %h expected %h", rd, model_sr); else n_pass++;
    endtask

    task automatic test_erase();
        int low;
        logic [7:0] rd;
        bus_write(8'h00, 8'h20);
        write_timed(8'h00, 8'hD0, 400, low);
        n_checks++;
        if (low !== ERASE_CYCLES) $display("FAIL erase_busy_cycles: got %0d expected %0d", low, ERASE_CYCLES); else n_pass++;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL erase_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'hFF);
        for (int i = 0; i < 256; i++) begin
            bus_read(8'(i), rd);
            n_checks++;
            if (rd !== model_mem[i]) $display("FAIL erase_read[%0d]: got %h expected %h", i, rd, model_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_program();
        int low;
        logic [7:0] rd, a, d;
        logic [7:0] addrs [$];
        logic [7:0] fixed_data [2];
        fixed_data[0] = 8'hC9; fixed_data[1] = 8'h3F;
        for (int k = 0; k < 2; k++) begin
            bus_write(8'h00, 8'h40);
            write_timed(8'h35, fixed_data[k], 60, low);
            model_mem[8'h35] = model_mem[8'h35] & fixed_data[k];
            n_checks++;
            if (low !== PROG_CYCLES) $display("FAIL prog_busy_cycles: got %0d expected %0d", low, PROG_CYCLES); else n_pass++;
            bus_write(8'h00, 8'hFF);
            bus_read(8'h35, rd);
            n_checks++;
            if (rd !== model_mem[8'h35]) $display("FAIL prog_fixed_read: got %h expected %h", rd, model_mem[8'h35]); else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            bus_write(8'h00, (i % 2 == 0) ? 8'h40 : 8'h10);
            write_timed(a, d, 60, low);
            model_mem[a] = model_mem[a] & d;
            addrs.push_back(a);
            n_checks++;
            if (low !== PROG_CYCLES) $display("FAIL prog_rand_busy: got %0d expected %0d", low, PROG_CYCLES); else n_pass++;
            bus_read(8'h00, rd);
            n_checks++;
            if (rd !== model_sr) $display("FAIL prog_rand_sr: got %h expected %h", rd, model_sr); else n_pass++;
        end
        bus_write(8'h00, 8'hFF);
        foreach (addrs[i]) begin
            bus_read(addrs[i], rd);
            n_checks++;
            if (rd !== model_mem[addrs[i]]) $display("FAIL prog_rand_read[%h]: got %h expected %h", addrs[i], rd, model_mem[addrs[i]]); else n_pass++;
        end
    endtask

    task automatic test_write_protect();
        int low;
        logic [7:0] rd;
        nf_wp = 1'b0;
        bus_write(8'h00, 8'h40);
        write_timed(8'h10, 8'($urandom_range(0, 255)), 40, low);
        model_sr = model_sr | 8'h12;
        n_checks++;
        if (low !== 0) $display("FAIL wp_prog_busy: got %0d expected 0", low); else n_pass++;
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL wp_prog_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'hFF);
        bus_read(8'h10, rd);
        n_checks++;
        if (rd !== model_mem[8'h10]) $display("FAIL wp_prog_array: got %h expected %h", rd, model_mem[8'h10]); else n_pass++;
        bus_write(8'h00, 8'h50);
        model_sr = 8'h80;
        bus_write(8'h00, 8'h70);
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL wp_clear_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'h20);
        write_timed(8'h00, 8'hD0, 40, low);
        model_sr = model_sr | 8'h22;
        n_checks++;
        if (low !== 0) $display("FAIL wp_erase_busy: got %0d expected 0", low); else n_pass++;
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL wp_erase_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'h50);
        model_sr = 8'h80;
        nf_wp = 1'b1;
    endtask

    task automatic test_sequence_error();
        logic [7:0] rd, a;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'h55);
        model_sr = model_sr | 8'h30;
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL seq_err_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 8'h35 : 8'($urandom_range(0, 255));
            bus_read(a, rd);
            n_checks++;
            if (rd !== model_mem[a]) $display("FAIL seq_err_array[%h]: got %h expected %h", a, rd, model_mem[a]); else n_pass++;
        end
        bus_write(8'h00, 8'h50);
        model_sr = 8'h80;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        bit ok;
        bus_write(8'h00, 8'h70);
        bus_write(8'h00, 8'h99);
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL ignored_opcode_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'h20);
        bus_write(8'h00, 8'hD0);
        bus_write(8'h00, 8'hFF);
        bus_write(8'h44, 8'h40);
        bus_write(8'h44, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nf_sts === 1'b1) begin ok = 1'b1; break; end
        end
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
        n_checks++;
        if (!ok) $display("FAIL busy_writes_ready: got busy expected ready within 400 cycles"); else n_pass++;
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL busy_writes_mode: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'hFF);
        bus_read(8'h44, rd);
        n_checks++;
        if (rd !== model_mem[8'h44]) $display("FAIL busy_writes_array: got %h expected %h", rd, model_mem[8'h44]); else n_pass++;
    endtask

    task automatic test_abort();
        int low;
        bit fired;
        logic [7:0] rd, a, d;
        for (int i = 0; i < 16; i++) begin
            a = (i < 8) ? 8'($urandom_range(0, 99)) : 8'($urandom_range(100, 255));
            d = 8'($urandom_range(0, 254));
            bus_write(8'h00, 8'h40);
            write_timed(a, d, 60, low);
            model_mem[a] = model_mem[a] & d;
        end
        bus_write(8'h00, 8'h20);
        @(negedge clk);
        nf_a = 8'h00; d_drv = 8'hD0; d_oe = 1'b1; nf_ce = 1'b0; nf_we = 1'b0;
        repeat (3) @(negedge clk);
        nf_we = 1'b1;
        low = 0; fired = 1'b0;
        // RP falls in busy cycle 98 so its synchronized copy lands on cycle 100.
        for (int i = 0; i < 400 && !fired; i++) begin
            @(negedge clk);
            if (i == 3) begin nf_ce = 1'b1; d_oe = 1'b0; end
            if (nf_sts === 1'b0) low++;
            if (low == 99) begin nf_rp = 1'b0; fired = 1'b1; end
        end
        nf_ce = 1'b1; d_oe = 1'b0;
        repeat (2) @(negedge clk);
        nf_rp = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 100; i++) model_mem[i] = 8'hFF;
        model_sr = 8'h80;
        n_checks++;
        if (!fired) $display("FAIL abort_reached: got %0d busy cycles expected 99", low); else n_pass++;
        n_checks++;
        if (nf_sts !== 1'b1) $display("FAIL abort_sts: got %b expected 1", nf_sts); else n_pass++;
        for (int i = 0; i < 256; i++) begin
            bus_read(8'(i), rd);
            n_checks++;
            if (rd !== model_mem[i]) $display("FAIL abort_read[%0d]: got %h expected %h", i, rd, model_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_bus();
        int low;
        logic [7:0] rd;
        bus_write(8'h00, 8'h70);
        @(negedge clk);
        nf_ce = 1'b0; nf_oe = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (nf_d !== 8'hFF) $display("FAIL bus_oe_high: got %h expected FF (released)", nf_d); else n_pass++;
        nf_oe = 1'b0; #1;
        n_checks++;
        if (nf_d !== model_sr) $display("FAIL bus_oe_low: got %h expected %h", nf_d, model_sr); else n_pass++;
        nf_we = 1'b0; #1;
        n_checks++;
        if (nf_d !== 8'hFF) $display("FAIL bus_we_low: got %h expected FF (released)", nf_d); else n_pass++;
        nf_ce = 1'b1; nf_oe = 1'b1;
        repeat (3) @(negedge clk);
        nf_we = 1'b1;
        repeat (3) @(negedge clk);
        bus_write(8'h00, 8'h40);
        write_timed(8'h77, 8'hFF, 6, low);
        n_checks++;
        if (low == 0) $display("FAIL rst_prog_started: got %0d busy cycles expected >0", low); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (nf_sts !== 1'b1) $display("FAIL rst_async_sts: got %b expected 1", nf_sts); else n_pass++;
        @(negedge clk); rst = 1'b0;
        model_sr = 8'h80;
        repeat (4) @(negedge clk);
        bus_write(8'h00, 8'h70);
        bus_read(8'h00, rd);
        n_checks++;
        if (rd !== model_sr) $display("FAIL rst_sr: got %h expected %h", rd, model_sr); else n_pass++;
        bus_write(8'h00, 8'hFF);
        bus_read(8'h77, rd);
        n_checks++;
        if (rd !== model_mem[8'h77]) $display("FAIL rst_array: got %h expected %h", rd, model_mem[8'h77]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_erase();
        test_program();
        test_write_protect();
        test_sequence_error();
        test_back_to_back();
        test_abort();
        test_bus();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_responder.md
FLASH_RESPONDER -- requirements
Module: flash_responder

Interface
REQ-001 Parameter PROG_CYCLES, default 16, busy time of one program operation in CLK cycles.
REQ-002 Parameter ERASE_CYCLES, default 256, busy time of one erase operation in CLK cycles; value SHALL be at least 256.
REQ-003 CLK  input  1  single clock for all logic; oversamples the flash bus.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 NF_CE  input  1  chip enable, active-low.
REQ-006 NF_OE  input  1  output enable, active-low.
REQ-007 NF_WE  input  1  write enable, active-low; command and data are captured on its rising edge.
REQ-008 NF_RP  input  1  reset/power-down, active-low.
REQ-009 NF_WP  input  1  write protect, active-low.
REQ-010 NF_BYTE  input  1  byte mode select; ignored, byte mode only.
REQ-011 NF_A  input  8  byte address.
REQ-012 NF_D  inout  8  data bus.
REQ-013 NF_STS  output  1  status; 0 while busy, 1 when ready.

Function
REQ-014 The block SHALL contain a 256x8 array and an 8-bit status register SR, with SR.7 = ready, SR.5 = erase error, SR.4 = program error, SR.1 = locked.
REQ-015 NF_WE, NF_CE, NF_A and NF_D SHALL pass through a 2-flop synchronizer; a write cycle is the synchronized WE rising edge while synchronized CE is 0, captured into cmd_addr/cmd_data.
REQ-016 States: READ_ARRAY, READ_STATUS, PROG_SETUP, PROG_BUSY, ERASE_SETUP, ERASE_BUSY.
REQ-017 Command decoding in READ_ARRAY and READ_STATUS:
- 0xFF -> READ_ARRAY
- 0x70 -> READ_STATUS
- 0x50 -> clear SR.5, SR.4 and SR.1; mode unchanged
- 0x40 or 0x10 -> PROG_SETUP
- 0x20 -> ERASE_SETUP
- any other opcode -> ignored
REQ-018 In PROG_SETUP, the next write cycle SHALL program: mem[cmd_addr] <= mem[cmd_addr] AND cmd_data, so bits can only be cleared. The block then enters PROG_BUSY for PROG_CYCLES cycles and moves to READ_STATUS.
REQ-019 In ERASE_SETUP, a write of 0xD0 SHALL enter ERASE_BUSY: one location per cycle is set to 0xFF, addresses 0..255 in order. Completion is at ERASE_CYCLES, after which the block moves to READ_STATUS. Any other data SHALL set SR.5 and SR.4 and go to READ_STATUS (sequence error).
REQ-020 If NF_WP = 0 when program or erase would start, the array SHALL stay unchanged. The block SHALL set SR.1 and either SR.4 (program) or SR.5 (erase), then go to READ_STATUS with no busy phase.
REQ-021 In the busy states, SR.7 = 0, NF_STS = 0 and write cycles are ignored; NF_STS SHALL return to 1 in the same cycle that SR.7 returns to 1.
REQ-022 NF_D SHALL be driven only when NF_CE = 0, NF_OE = 0, NF_WE = 1 and NF_RP = 1 (combinational from the pins); otherwise it is high-Z.
REQ-023 The read data register SHALL load every CLK: mem[A_sync] in READ_ARRAY, SR in all other states. Latency from a stable address to valid data is 3 CLK.
REQ-024 Simultaneous write cycle and busy completion: completion SHALL take priority and the write SHALL be dropped.

Reset
REQ-025 RST = 1 asynchronously SHALL force state READ_ARRAY, SR = 0x80, NF_STS = 1, NF_D high-Z, synchronizers cleared, busy counter = 0.
REQ-026 NF_RP = 0 (synchronized) SHALL apply the same state as REQ-025 synchronously. A program or erase in progress SHALL be aborted; locations already erased remain 0xFF and the rest are unchanged.
REQ-027 The array contents SHALL NOT be reset by RST.

Structure
REQ-028 A shared package flash_pkg SHALL hold the command opcodes, the SR bit indices and the state enumeration.
REQ-029 One sub-module, flash_sync (2-flop synchronizer with rising-edge detect), SHALL be instantiated for NF_WE; the array SHALL be inferred as a synchronous RAM.

Verification
REQ-030 Erase: write 0x20, then 0xD0 -> NF_STS low for 256 cycles, then high; SR reads 0x80; every address reads 0xFF.
REQ-031 Program: write 0x40, then A = 0x35 with D = 0xC9 -> NF_STS low for 16 cycles; after 0xFF, address 0x35 reads 0xC9. Reprogramming with 0x3F then reads 0x09.
REQ-032 Write-protect: NF_WP = 0, program A = 0x10 -> no busy phase; SR = 0x92; address 0x10 unchanged. After 0x50, SR = 0x80.
REQ-033 Sequence error: write 0x20 then 0x55 -> SR = 0xB0; array unchanged.
REQ-034 Abort: pulse NF_RP low at erase cycle 100 -> NF_STS = 1; mode is READ_ARRAY; addresses 0..99 read 0xFF and the rest are unchanged.
REQ-035 Bus: with NF_OE = 1, or NF_WE = 0, NF_D SHALL read as Z; assert RST mid-program -> NF_STS = 1 asynchronously.
